// File: rtl/alu_pkg.sv
// Shared ALUControl encoding, FSM state type and op classification for the
// ALU decoder and the sequential execute-stage ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SGE  = 4'b0111;
    localparam logic [3:0] ALU_UGE  = 4'b1000;
    localparam logic [3:0] ALU_EQ   = 4'b1001;
    localparam logic [3:0] ALU_NE   = 4'b1010;
    localparam logic [3:0] ALU_SLL  = 4'b1011;
    localparam logic [3:0] ALU_SRL  = 4'b1100;
    localparam logic [3:0] ALU_SRA  = 4'b1101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational non-shift datapath: add/sub, logic ops and compares.
// Shift and illegal codes yield zero; shifts are produced by alu_seq.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic lt_s;
    logic lt_u;

    assign lt_s = $signed(a) < $signed(b);
    assign lt_u = a < b;

    // NOTE: y gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_SLT:  y[0] = lt_s;
            ALU_SLTU: y[0] = lt_u;
            ALU_SGE:  y[0] = !lt_s;
            ALU_UGE:  y[0] = !lt_u;
            ALU_EQ:   y[0] = (a == b);
            ALU_NE:   y[0] = (a != b);
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU with start/done handshake; shifts iterate one
// bit per cycle unless ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [SW-1:0]    cnt;
    logic [3:0]       op_q;

    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] first_shift;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] start_res;
    logic             long_shift;

    function automatic logic [WIDTH-1:0] shift1(input logic [3:0] op, input logic [WIDTH-1:0] x);
        case (op)
            ALU_SLL: return {x[WIDTH-2:0], 1'b0};
            ALU_SRL: return {1'b0, x[WIDTH-1:1]};
            default: return {x[WIDTH-1], x[WIDTH-1:1]};
        endcase
    endfunction

`ifdef ALU_BARREL_SHIFT_EN
    function automatic logic [WIDTH-1:0] barrel(input logic [3:0] op, input logic [WIDTH-1:0] x,
                                                input logic [SW-1:0] n);
        case (op)
            ALU_SLL: return x << n;
            ALU_SRL: return x >> n;
            default: return WIDTH'($signed(x) >>> n);
        endcase
    endfunction
`endif

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op (alu_control),
        .a  (src_a),
        .b  (src_b),
        .y  (core_y)
    );

    assign shamt       = src_b[SW-1:0];
    assign first_shift = shift1(alu_control, src_a);
    assign acc_next    = shift1(op_q, acc);

    // Everything except a multi-bit iterative shift finishes at the accepting edge.
    always_comb begin
        start_res  = core_y;
        long_shift = 1'b0;
        if (is_shift(alu_control)) begin
`ifdef ALU_BARREL_SHIFT_EN
            start_res = barrel(alu_control, src_a, shamt);
`else
            start_res  = (shamt == '0) ? src_a : first_shift;
            long_shift = (shamt > SW'(1));
`endif
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
            acc    <= '0;
            cnt    <= '0;
            op_q   <= ALU_ADD;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (long_shift) begin
                            acc   <= first_shift;
                            cnt   <= shamt - 1'b1;
                            op_q  <= alu_control;
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end else begin
                            result <= start_res;
                            zero   <= (start_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == SW'(1)) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                        zero   <= (acc_next == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues expected result/zero/done-cycle,
// an independent monitor pops and compares on every done pulse.
module tb_alu_seq;
    import alu_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [3:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          done_cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e_m;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .alu_control (alu_control),
        .src_a       (src_a),
        .src_b       (src_b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .zero        (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: sample one time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check("no_spurious_done", 32'(done), 32'd0);
            end else begin
                e_m = sb.pop_front();
                check({e_m.name, "_result"}, result, e_m.res);
                check({e_m.name, "_zero"}, 32'(zero), 32'(e_m.z));
                check({e_m.name, "_latency_cycle"}, cyc, e_m.done_cyc);
            end
        end
    end

    function automatic int shift_lat(input int n);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        return (n > 1) ? n : 1;
`endif
    endfunction

    // Called at a negedge; leaves the bench at the negedge where done is high.
    task automatic wait_done(input string name, output int busy_n);
        busy_n = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            if (busy) busy_n++;
            @(negedge clk);
        end
        if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int lat);
        sb.push_back('{res: exp_r, z: (exp_r == 32'd0), done_cyc: cyc + lat, name: name});
        alu_control = op;
        src_a       = a;
        src_b       = b;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_r, input int lat,
                       output int busy_n);
        issue(name, op, a, b, exp_r, lat);
        wait_done(name, busy_n);
    endtask

    int bc;

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        alu_control = ALU_ADD;
        src_a       = '0;
        src_b       = '0;
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", 32'(zero), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run("add_wrap", ALU_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, bc);
        run("sub", ALU_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, bc);
        run("and", ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1, bc);
        run("or", ALU_OR, 32'h0F, 32'hF0, 32'hFF, 1, bc);
        run("slt", ALU_SLT, 32'hFFFF_FFFE, 32'd1, 32'd1, 1, bc);
        run("sltu", ALU_SLTU, 32'hFFFF_FFFE, 32'd1, 32'd0, 1, bc);
        run("sge", ALU_SGE, 32'hFFFF_FFFE, 32'd1, 32'd0, 1, bc);
        run("uge", ALU_UGE, 32'hFFFF_FFFE, 32'd1, 32'd1, 1, bc);
        run("eq", ALU_EQ, 32'd5, 32'd5, 32'd1, 1, bc);
        run("ne", ALU_NE, 32'd5, 32'd5, 32'd0, 1, bc);

        run("sra31", ALU_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, shift_lat(31), bc);
        check("sra31_busy_cycles", bc, shift_lat(31) - 1);
        run("sra4_pos", ALU_SRA, 32'h7000_0000, 32'd4, 32'h0700_0000, shift_lat(4), bc);
        run("sll31", ALU_SLL, 32'h3, 32'd31, 32'h8000_0000, shift_lat(31), bc);
        run("srl1", ALU_SRL, 32'h8000_0000, 32'd1, 32'h4000_0000, 1, bc);
        run("sll_shamt_lowbits", ALU_SLL, 32'd1, 32'h25, 32'h20, shift_lat(5), bc);

        // Start pulse while busy must be ignored, inputs changing mid-shift have no effect.
        issue("sll4", ALU_SLL, 32'd1, 32'd4, 32'h10, shift_lat(4));
`ifndef ALU_BARREL_SHIFT_EN
        check("sll4_busy", 32'(busy), 32'd1);
        alu_control = ALU_ADD;
        src_a       = 32'h1234_5678;
        src_b       = 32'd3;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
`endif
        wait_done("sll4", bc);
        check("b2b_done_window", 32'(done), 32'd1);
        run("xor_b2b", ALU_XOR, 32'hF0, 32'hFF, 32'h0F, 1, bc);

        run("illegal", 4'b1111, 32'hDEAD_BEEF, 32'h1, 32'd0, 1, bc);
        run("srl0", ALU_SRL, 32'h1234, 32'd0, 32'h1234, 1, bc);

        // Reset mid-shift: outputs clear at once and the aborted shift never completes.
`ifdef ALU_BARREL_SHIFT_EN
        run("sll20", ALU_SLL, 32'd1, 32'd20, 32'h0010_0000, 1, bc);
`else
        alu_control = ALU_SLL;
        src_a       = 32'd1;
        src_b       = 32'd20;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
`endif
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'd0);
        check("async_reset_done", 32'(done), 32'd0);
        check("async_reset_result", result, 32'd0);
        check("async_reset_zero", 32'(zero), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_reset_idle_busy", 32'(busy), 32'd0);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Multi-cycle execute-stage ALU, directly downstream of the ALU decoder.
- Consumes the 4-bit ALUControl code plus two operands and produces the result and a zero flag.
- Non-shift operations complete in 1 cycle; shifts run iteratively at 1 bit per cycle.
- Uses a start/done handshake so the controller can stall while a shift is in progress.

Parameters:
- WIDTH, 32, operand/result width; shift amount width SW = $clog2(WIDTH).

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- alu_control  in  4  operation code (encoding below)
- src_a  in  WIDTH  operand A
- src_b  in  WIDTH  operand B; shift amount is src_b[SW-1:0]
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse; result/zero valid that cycle and held until the next done
- result  out  WIDTH  registered result
- zero  out  1  registered (result == 0)

Behaviour:
- Encoding:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor
  - 0101 slt (signed), 0110 sltu
  - 0111 sge (signed >=), 1000 uge (unsigned >=)
  - 1001 eq, 1010 ne
  - 1011 sll, 1100 srl, 1101 sra
  - 1110/1111 illegal
- Compare/branch codes (0101-1010): result = {WIDTH-1 zeros, cond}.
- Arithmetic wraps modulo 2^WIDTH; carry and overflow are discarded.
- Illegal codes: result = 0, zero = 1, done with 1-cycle latency.
- States: IDLE, SHIFT.
- IDLE, start=1, non-shift op:
  - result registered at the same edge; done=1 in the following cycle.
  - Latency 1; stays in IDLE.
- IDLE, start=1, shift op with n = shamt:
  - n == 0: result = src_a, done next cycle, latency 1.
  - n > 0: accumulator loads src_a shifted by 1 and cnt = n-1.
    - If cnt == 0, done next cycle.
    - Otherwise go to SHIFT with busy=1.
- SHIFT, each edge: accumulator shifts by 1 and cnt decrements.
  - The edge at which cnt reaches 0 returns to IDLE, drops busy and raises done.
  - Total latency = max(1, n) cycles; n = WIDTH-1 is the maximum.
- sra replicates the sign bit captured at start.
- Operands and op are captured at start; input changes during SHIFT have no effect.
- start while busy is ignored: no queueing, no error.
- start asserted in the same cycle done is high is accepted normally, giving back-to-back ops.
- done is never high for two consecutive cycles from a single request.
- Reset (asynchronous, any state):
  - state = IDLE; busy = 0, done = 0, result = 0, zero = 1; cnt and accumulator cleared.
  - An in-flight shift is aborted with no done.

Optional Feature:
- ALU_BARREL_SHIFT_EN
- Defined: shifts use a combinational barrel shifter. All ops, including shifts of any amount, have latency 1; SHIFT state is unused and busy is tied 0.
- Undefined: iterative shifting as specified above.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit ALUControl localparams (ALU_ADD … ALU_SRA);
  - the state enum (IDLE, SHIFT);
  - a function is_shift(op).
- The ALU decoder imports the same package, so the encoding has a single source.
- One sub-module, alu_core: combinational non-shift datapath (add/sub/logic/compares) producing next-result.
- alu_seq owns the FSM, shift accumulator, counter and output registers.

Test Plan:
- Reset: drive reset_n=0 mid-SHIFT (sll, shamt=20, after 5 cycles) -> immediately busy=0, done=0, result=0, zero=1; no done after release.
- Add wrap: start, 0000, a=0xFFFFFFFF, b=1 -> next cycle done=1, result=0, zero=1.
- Branch compares:
  - 0111 with a=0xFFFFFFFE (-2), b=1 -> result=0.
  - 1000 with same operands -> result=1.
  - 1010 with a=b=5 -> result=0, zero=1.
- sra: a=0x80000000, shamt=31 -> busy for 30 cycles, done exactly 31 cycles after start, result=0xFFFFFFFF.
  - With ALU_BARREL_SHIFT_EN: done after 1 cycle, same result.
- Ignore and back-to-back:
  - sll a=1, shamt=4; pulse start with add while busy -> ignored; done at cycle 4 with result=0x10.
  - start asserted in the done cycle (xor a=0xF0, b=0xFF) -> done next cycle, result=0x0F.
- Illegal and shamt 0:
  - 1111 -> 1-cycle done, result=0, zero=1.
  - srl a=0x1234, shamt=0 -> 1-cycle done, result=0x1234.
